// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO and valid/ready handshake.
// A baud-tick counter in the clk domain times every bit; back-to-back frames leave no idle gap.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 baud_end;

  state_t               state;
  logic [BW-1:0]        baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shifter;
  logic                 parity_bit;

  assign tx_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (fifo_count == '0);
  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign head       = mem[rd_ptr];

  // Pop from IDLE, or on the last cycle of the final stop bit so the next start bit follows at once.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == S_IDLE) begin
        pop = 1'b1;
      end else if (state == S_STOP && baud_end && bit_idx == STOP_LAST) begin
        pop = 1'b1;
      end
    end
  end

  // NOTE: the storage array carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // tx is registered and always reflects the bit of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else if (pop) begin
      state      <= S_START;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shifter    <= head;
      parity_bit <= (PARITY == 1) ? ~(^head) : (^head);
      tx         <= 1'b0;
      busy       <= 1'b1;
    end else begin
      baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
        S_START: begin
          if (baud_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shifter[0];
          end
        end
        S_DATA: begin
          if (baud_end) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              shifter <= shifter >> 1;
              tx      <= shifter[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            state   <= S_STOP;
            bit_idx <= '0;
            tx      <= 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            if (bit_idx == STOP_LAST) begin
              state   <= S_IDLE;
              bit_idx <= '0;
              busy    <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
